// File: rtl/board_game_ctrl.sv
// board_game_ctrl: N x N, K-in-a-row two-player game controller.
// Owns board storage, cursor, turn sequencing and a serial win/draw scan.
// Optional feature: define TURN_TIMEOUT_EN to forfeit a turn after
// TIMEOUT_CYC idle cycles in PLAY; otherwise turn_timeout is tied low.

module board_game_ctrl #(
    parameter int unsigned N           = 3,
    parameter int unsigned K           = 3,
    parameter int unsigned TIMEOUT_CYC = 250_000_000,
    localparam int unsigned CW         = $clog2(N * N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_pulse,
    input  logic          move_pulse,
    input  logic          assign_pulse,
    input  logic [CW-1:0] rd_addr,
    output logic [1:0]    rd_data,
    output logic [CW-1:0] cursor,
    output logic          turn,
    output logic [2:0]    state,
    output logic [1:0]    winner,
    output logic          place_ok,
    output logic          place_reject,
    output logic          turn_timeout
);

    localparam int unsigned CELLS = N * N;
    localparam int unsigned MW    = $clog2(CELLS + 1);
    localparam int unsigned SPAN  = 2 * K - 1;
    localparam int unsigned SW    = $clog2(SPAN);
    localparam int unsigned RW    = $clog2(K + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_PLAY  = 3'd2,
        S_CHECK = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    state_t st, st_nxt;

    // button edge detection
    logic start_q, move_q, assign_q;
    logic start_e, move_e, assign_e;

    // board storage and its single write port
    logic [1:0]    board [CELLS];
    logic          wr_en;
    logic [CW-1:0] wr_idx;
    logic [1:0]    wr_val;

    // datapath registers and their next values
    logic [CW-1:0] clr_idx, clr_idx_nxt;
    logic [MW-1:0] move_cnt, move_cnt_nxt;
    logic [1:0]    dir, dir_nxt;
    logic [SW-1:0] step, step_nxt;
    logic [RW-1:0] run, run_nxt;
    logic          win_hit, win_hit_nxt;
    logic [CW-1:0] cursor_nxt;
    logic          turn_nxt;
    logic [1:0]    winner_nxt;
    logic          place_ok_nxt, place_reject_nxt;

    // scan evaluation
    int            px, py, off, dx, dy, sx, sy;
    logic          on_board, match;
    logic [1:0]    scan_cell;
    logic [RW-1:0] run_inc;
    logic          step_hit, step_last, scan_last, win_any, full;
    logic [1:0]    mark;
    logic          cur_empty;
    logic          last_clear;

`ifdef TURN_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [TW-1:0] tmr, tmr_nxt;
    logic          timeout_nxt;
`endif

    assign state      = st;
    assign start_e    = start_pulse & ~start_q;
    assign move_e     = move_pulse & ~move_q;
    assign assign_e   = assign_pulse & ~assign_q;
    assign mark       = turn ? 2'b10 : 2'b01;
    assign cur_empty  = (board[cursor] == 2'b00);
    assign full       = (move_cnt == MW'(CELLS));
    assign last_clear = (clr_idx == CW'(CELLS - 1));

    // walk one cell of the current direction around the placed cell
    always_comb begin
        px  = int'(cursor) % int'(N);
        py  = int'(cursor) / int'(N);
        off = int'(step) - int'(K) + 1;
        dx  = 1;
        dy  = 0;
        case (dir)
            2'd1:    begin dx = 0; dy = 1;  end
            2'd2:    begin dx = 1; dy = 1;  end
            2'd3:    begin dx = 1; dy = -1; end
            default: begin dx = 1; dy = 0;  end
        endcase
        sx        = px + dx * off;
        sy        = py + dy * off;
        on_board  = (sx >= 0) && (sx < int'(N)) && (sy >= 0) && (sy < int'(N));
        scan_cell = 2'b00;
        if (on_board) begin
            scan_cell = board[CW'(sy * int'(N) + sx)];
        end
        match   = on_board && (scan_cell == mark);
        run_inc = '0;
        if (match) begin
            run_inc = (run == RW'(K)) ? run : run + RW'(1);
        end
        step_hit  = match && (run_inc == RW'(K));
        step_last = (step == SW'(SPAN - 1));
        scan_last = step_last && (dir == 2'd3);
        win_any   = win_hit | step_hit;
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st <= S_IDLE;
        end else begin
            st <= st_nxt;
        end
    end

    // next-state logic
    always_comb begin
        st_nxt = st;
        case (st)
            S_IDLE:  if (start_e) st_nxt = S_CLEAR;
            S_CLEAR: if (last_clear) st_nxt = S_PLAY;
            S_PLAY:  if (assign_e && cur_empty) st_nxt = S_CHECK;
            S_CHECK: begin
                if (scan_last) begin
                    st_nxt = (win_any || full) ? S_OVER : S_PLAY;
                end
            end
            S_OVER:  if (start_e) st_nxt = S_CLEAR;
            default: st_nxt = S_IDLE;
        endcase
    end

    // datapath and output next values
    always_comb begin
        cursor_nxt       = cursor;
        turn_nxt         = turn;
        winner_nxt       = winner;
        move_cnt_nxt     = move_cnt;
        clr_idx_nxt      = clr_idx;
        dir_nxt          = dir;
        step_nxt         = step;
        run_nxt          = run;
        win_hit_nxt      = win_hit;
        place_ok_nxt     = 1'b0;
        place_reject_nxt = 1'b0;
        wr_en            = 1'b0;
        wr_idx           = cursor;
        wr_val           = mark;
`ifdef TURN_TIMEOUT_EN
        tmr_nxt          = tmr;
        timeout_nxt      = 1'b0;
`endif
        case (st)
            S_IDLE: begin
                if (start_e) clr_idx_nxt = '0;
            end
            S_CLEAR: begin
                wr_en       = 1'b1;
                wr_idx      = clr_idx;
                wr_val      = 2'b00;
                clr_idx_nxt = clr_idx + CW'(1);
                if (last_clear) begin
                    cursor_nxt   = '0;
                    turn_nxt     = 1'b0;
                    winner_nxt   = 2'b00;
                    move_cnt_nxt = '0;
`ifdef TURN_TIMEOUT_EN
                    tmr_nxt      = '0;
`endif
                end
            end
            S_PLAY: begin
                if (assign_e && cur_empty) begin
                    wr_en        = 1'b1;
                    place_ok_nxt = 1'b1;
                    move_cnt_nxt = move_cnt + MW'(1);
                    dir_nxt      = 2'd0;
                    step_nxt     = '0;
                    run_nxt      = '0;
                    win_hit_nxt  = 1'b0;
                end else begin
                    if (assign_e) begin
                        place_reject_nxt = 1'b1;
                    end else if (move_e) begin
                        cursor_nxt = (cursor == CW'(CELLS - 1)) ? '0 : cursor + CW'(1);
                    end
`ifdef TURN_TIMEOUT_EN
                    if (tmr == TW'(TIMEOUT_CYC - 1)) begin
                        tmr_nxt     = '0;
                        timeout_nxt = 1'b1;
                        turn_nxt    = ~turn;
                    end else begin
                        tmr_nxt = tmr + TW'(1);
                    end
`endif
                end
            end
            S_CHECK: begin
                win_hit_nxt = win_any;
                if (step_last) begin
                    step_nxt = '0;
                    dir_nxt  = dir + 2'd1;
                    run_nxt  = '0;
                end else begin
                    step_nxt = step + SW'(1);
                    run_nxt  = run_inc;
                end
                if (scan_last) begin
                    if (win_any) begin
                        winner_nxt = mark;
                    end else if (full) begin
                        winner_nxt = 2'b11;
                    end else begin
                        turn_nxt = ~turn;
`ifdef TURN_TIMEOUT_EN
                        tmr_nxt  = '0;
`endif
                    end
                end
            end
            S_OVER: begin
                if (start_e) clr_idx_nxt = '0;
            end
            default: ;
        endcase
    end

    // datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q      <= 1'b0;
            move_q       <= 1'b0;
            assign_q     <= 1'b0;
            cursor       <= '0;
            turn         <= 1'b0;
            winner       <= 2'b00;
            move_cnt     <= '0;
            clr_idx      <= '0;
            dir          <= 2'd0;
            step         <= '0;
            run          <= '0;
            win_hit      <= 1'b0;
            place_ok     <= 1'b0;
            place_reject <= 1'b0;
        end else begin
            start_q      <= start_pulse;
            move_q       <= move_pulse;
            assign_q     <= assign_pulse;
            cursor       <= cursor_nxt;
            turn         <= turn_nxt;
            winner       <= winner_nxt;
            move_cnt     <= move_cnt_nxt;
            clr_idx      <= clr_idx_nxt;
            dir          <= dir_nxt;
            step         <= step_nxt;
            run          <= run_nxt;
            win_hit      <= win_hit_nxt;
            place_ok     <= place_ok_nxt;
            place_reject <= place_reject_nxt;
        end
    end

`ifdef TURN_TIMEOUT_EN
    // turn timer, counts only in PLAY
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr          <= '0;
            turn_timeout <= 1'b0;
        end else begin
            tmr          <= tmr_nxt;
            turn_timeout <= timeout_nxt;
        end
    end
`else
    assign turn_timeout = 1'b0;
`endif

    // board storage, cleared by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(CELLS); i++) begin
                board[i] <= 2'b00;
            end
        end else if (wr_en) begin
            board[wr_idx] <= wr_val;
        end
    end

    // renderer read port, one-cycle latency; out-of-range indices read empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= 2'b00;
        end else begin
            rd_data <= (32'(rd_addr) < CELLS) ? board[rd_addr] : 2'b00;
        end
    end

endmodule

// File: tb/tb_board_game_ctrl.sv
// Scoreboard bench for board_game_ctrl (N=3, K=3, TIMEOUT_CYC=16).
// Stimulus tasks push expected events; a monitor pops and compares them.

module tb_board_game_ctrl;

    localparam int NN = 3;
    localparam int KK = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_pulse = 1'b0;
    logic       move_pulse = 1'b0;
    logic       assign_pulse = 1'b0;
    logic [3:0] rd_addr = '0;
    logic [1:0] rd_data;
    logic [3:0] cursor;
    logic       turn;
    logic [2:0] state;
    logic [1:0] winner;
    logic       place_ok, place_reject, turn_timeout;

    board_game_ctrl #(.N(NN), .K(KK), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .start_pulse(start_pulse), .move_pulse(move_pulse), .assign_pulse(assign_pulse),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .cursor(cursor), .turn(turn), .state(state), .winner(winner),
        .place_ok(place_ok), .place_reject(place_reject), .turn_timeout(turn_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [2:0] st;
        logic       ok;
        logic       rej;
        logic       tmo;
        logic [3:0] cur;
        logic       trn;
        logic [1:0] win;
        int         dwell;
    } ev_t;

    ev_t        exp_q[$];
    logic [1:0] rd_q[$];
    int         checks = 0;
    int         errors = 0;
    logic       probe = 1'b0;
    logic       rd_chk = 1'b0;

    // reference model
    logic [1:0] mb [NN*NN];
    int         m_cur = 0;
    logic       m_turn = 1'b0;
    logic [1:0] m_win = 2'b00;
    int         m_cnt = 0;

    function automatic bit model_win(input logic [1:0] mk);
        bit f = 1'b0;
        for (int y = 0; y < NN; y++)
            for (int x = 0; x < NN; x++)
                for (int d = 0; d < 4; d++) begin
                    int dx = (d == 1) ? 0 : 1;
                    int dy = (d == 0) ? 0 : ((d == 3) ? -1 : 1);
                    bit all = 1'b1;
                    for (int i = 0; i < KK; i++) begin
                        int cx = x + i * dx;
                        int cy = y + i * dy;
                        if (cx < 0 || cx >= NN || cy < 0 || cy >= NN) all = 1'b0;
                        else if (mb[cy*NN+cx] != mk) all = 1'b0;
                    end
                    if (all) f = 1'b1;
                end
        return f;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_ev(input string tag, input logic [2:0] st, input logic ok,
                           input logic rej, input logic tmo, input int dwell);
        ev_t e;
        e.tag = tag; e.st = st; e.ok = ok; e.rej = rej; e.tmo = tmo;
        e.cur = 4'(m_cur); e.trn = m_turn; e.win = m_win; e.dwell = dwell;
        exp_q.push_back(e);
    endtask

    task automatic do_probe(input string tag, input logic [2:0] st);
        push_ev(tag, st, 1'b0, 1'b0, 1'b0, -1);
        probe = 1'b1;
        tick(1);
        probe = 1'b0;
    endtask

    task automatic rd_check(input int addr);
        rd_addr = 4'(addr);
        rd_q.push_back(mb[addr]);
        rd_chk = 1'b1;
        tick(1);
        rd_chk = 1'b0;
    endtask

    task automatic rd_all();
        for (int i = 0; i < NN*NN; i++) rd_check(i);
        tick(1);
    endtask

    task automatic clear_model();
        for (int i = 0; i < NN*NN; i++) mb[i] = 2'b00;
        m_cur = 0; m_turn = 1'b0; m_win = 2'b00; m_cnt = 0;
    endtask

    task automatic press_start();
        push_ev("clear_entry", 3'd1, 1'b0, 1'b0, 1'b0, -1);
        clear_model();
        push_ev("clear_done", 3'd2, 1'b0, 1'b0, 1'b0, NN*NN);
        start_pulse = 1'b1;
        tick(1);
        start_pulse = 1'b0;
        tick(11);
    endtask

    task automatic press_move();
        move_pulse = 1'b1;
        tick(1);
        move_pulse = 1'b0;
        tick(1);
        m_cur = (m_cur + 1) % (NN*NN);
    endtask

    task automatic goto_cell(input int t);
        while (m_cur != t) press_move();
    endtask

    task automatic place(input bit finish, input bit with_move);
        logic [1:0] mk;
        mk = m_turn ? 2'b10 : 2'b01;
        if (mb[m_cur] != 2'b00) begin
            push_ev("reject", 3'd2, 1'b0, 1'b1, 1'b0, -1);
            assign_pulse = 1'b1;
            move_pulse = with_move;
            tick(1);
            assign_pulse = 1'b0;
            move_pulse = 1'b0;
            tick(2);
        end else begin
            push_ev("place", 3'd3, 1'b1, 1'b0, 1'b0, -1);
            mb[m_cur] = mk;
            m_cnt++;
            if (finish) begin
                if (model_win(mk)) begin
                    m_win = mk;
                    push_ev("check_win", 3'd4, 1'b0, 1'b0, 1'b0, 4*(2*KK-1));
                end else if (m_cnt == NN*NN) begin
                    m_win = 2'b11;
                    push_ev("check_draw", 3'd4, 1'b0, 1'b0, 1'b0, 4*(2*KK-1));
                end else begin
                    m_turn = ~m_turn;
                    push_ev("check_next", 3'd2, 1'b0, 1'b0, 1'b0, 4*(2*KK-1));
                end
            end
            assign_pulse = 1'b1;
            move_pulse = with_move;
            tick(1);
            assign_pulse = 1'b0;
            move_pulse = 1'b0;
            if (finish) tick(22);
        end
    endtask

    task automatic reset_mid_check();
        goto_cell(4);
        place(1'b0, 1'b0);
        tick(5);
        clear_model();
        push_ev("reset_mid_check", 3'd0, 1'b0, 1'b0, 1'b0, -1);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);
        rd_all();
        do_probe("after_reset", 3'd0);
    endtask

    // monitor: compares every DUT event and every requested read
    initial begin : monitor
        logic [2:0] prev_st = 3'd0;
        logic       rd_pend = 1'b0;
        int         since = 0;
        bit         is_ev;
        ev_t        e;
        logic [1:0] er;
        forever begin
            @(negedge clk);
            since++;
            if (rd_pend) begin
                er = rd_q.pop_front();
                checks++;
                if (rd_data !== er) begin
                    errors++;
                    $display("FAIL rd_data: got %0d want %0d", rd_data, er);
                end
            end
            rd_pend = rd_chk;
            is_ev = (place_ok | place_reject | turn_timeout) === 1'b1 || (state !== prev_st);
            if (is_ev || probe) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: got st=%0d ok=%0b rej=%0b tmo=%0b cur=%0d, want none",
                             state, place_ok, place_reject, turn_timeout, cursor);
                end else begin
                    e = exp_q.pop_front();
                    if (state !== e.st || place_ok !== e.ok || place_reject !== e.rej ||
                        turn_timeout !== e.tmo || cursor !== e.cur || turn !== e.trn ||
                        winner !== e.win || (e.dwell >= 0 && e.dwell != since)) begin
                        errors++;
                        $display("FAIL %s: got st=%0d ok=%0b rej=%0b tmo=%0b cur=%0d turn=%0b win=%0d dwell=%0d, want st=%0d ok=%0b rej=%0b tmo=%0b cur=%0d turn=%0b win=%0d dwell=%0d",
                                 e.tag, state, place_ok, place_reject, turn_timeout, cursor, turn, winner, since,
                                 e.st, e.ok, e.rej, e.tmo, e.cur, e.trn, e.win, e.dwell);
                    end
                end
                if (is_ev) since = 0;
            end
            prev_st = state;
        end
    end

    // directed stimulus
    initial begin : stim
        clear_model();
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(2);
        do_probe("reset_state", 3'd0);
        rd_all();
        press_start();
        rd_all();
        do_probe("play_entry", 3'd2);
`ifndef TURN_TIMEOUT_EN
        // cursor wrap and held button
        for (int i = 0; i < NN*NN; i++) press_move();
        do_probe("cursor_wrap", 3'd2);
        move_pulse = 1'b1;
        tick(50);
        move_pulse = 1'b0;
        tick(1);
        m_cur = m_cur + 1;
        do_probe("held_move", 3'd2);

        // P1 wins on the top row
        goto_cell(0); place(1'b1, 1'b0);
        goto_cell(3); place(1'b1, 1'b0);
        goto_cell(1); place(1'b1, 1'b0);
        goto_cell(4); place(1'b1, 1'b0);
        goto_cell(2); place(1'b1, 1'b0);
        assign_pulse = 1'b1; tick(1); assign_pulse = 1'b0; tick(1);
        move_pulse = 1'b1; tick(1); move_pulse = 1'b0; tick(1);
        do_probe("over_frozen", 3'd4);
        rd_all();

        // rejects, simultaneous move+assign, then a draw
        press_start();
        goto_cell(0); place(1'b1, 1'b0);
        goto_cell(4); place(1'b1, 1'b0);
        place(1'b1, 1'b0);
        rd_check(4);
        tick(1);
        do_probe("after_reject", 3'd2);
        goto_cell(2); place(1'b1, 1'b1);
        do_probe("move_assign", 3'd2);
        goto_cell(1); place(1'b1, 1'b0);
        goto_cell(3); place(1'b1, 1'b0);
        goto_cell(5); place(1'b1, 1'b0);
        goto_cell(7); place(1'b1, 1'b0);
        goto_cell(6); place(1'b1, 1'b0);
        goto_cell(8); place(1'b1, 1'b0);
        rd_all();
        press_start();
        rd_all();
        do_probe("restart", 3'd2);
        reset_mid_check();
`else
        // idle in PLAY until the turn is forfeited
        m_turn = 1'b1;
        push_ev("timeout", 3'd2, 1'b0, 1'b0, 1'b1, 16);
        tick(1);
        tick(19);
        goto_cell(0);
        place(1'b0, 1'b0);
        tick(5);
        clear_model();
        push_ev("reset_mid_check", 3'd0, 1'b0, 1'b0, 1'b0, -1);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);
        rd_all();
        do_probe("after_reset", 3'd0);
`endif
        tick(5);
        checks++;
        if (exp_q.size() != 0 || rd_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_expectations: got %0d events %0d reads pending, want 0",
                     exp_q.size(), rd_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
